muldiv_unit: RTL
================

# muldiv_unit

Iterative RV32M multiply/divide execution unit in the EX stage, alongside the ALU. It consumes the funct3-decoded M-extension operation, sources and a start strobe, and signals occupancy to the hazard/stall logic. It returns a 32-bit result with a one-cycle valid pulse. Results are bit-exact to the RISC-V M specification, including divide-by-zero and signed-overflow cases.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when not busy.
- muldiv_op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- src1  in  XLEN  rs1 value; dividend or multiplicand.
- src2  in  XLEN  rs2 value; divisor or multiplier.
- flush  in  1  abort the current operation (branch mispredict or trap).
- busy  out  1  high while iterating; the pipeline stalls on it.
- valid  out  1  one-cycle pulse, result is meaningful.
- result  out  XLEN  result; held until the next accepted start.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- Accept: start=1 in IDLE or DONE and flush=0. The unit latches op, operand magnitudes and sign flags.
  - Sign flags: MULH/DIV/REM treat both operands as signed. MULHSU treats src1 signed, src2 unsigned. The others treat both as unsigned.
- MUL state: shift-add over magnitudes, 32 iterations into a 64-bit accumulator. The 5-bit counter counts 0..31.
- DIV state: radix-2 restoring divide over magnitudes, 32 iterations, producing quotient and remainder.
- FIX (1 cycle) selects the output:
  - Product: negated (64-bit) if operand signs differ. MUL takes bits [31:0]; MULH/MULHSU/MULHU take bits [63:32].
  - Quotient: negated if signs differ (signed ops).
  - Remainder: takes the dividend's sign.
- Special cases skip iteration, IDLE/DONE -> DONE directly:
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return src1.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000, REM returns 0.
- DONE: valid=1 for exactly one cycle. Without a new start the unit goes to IDLE. A start in DONE is accepted, so back-to-back operations are allowed.
- start while busy: ignored, not queued.
- flush: any state -> IDLE next edge. valid is suppressed and result keeps its previous value. If flush and start are high in the same cycle, flush wins and start is dropped.
- busy = state is MUL, DIV or FIX.

## Timing
- Reset values: state IDLE, busy 0, valid 0, result 0, counter 0, all internal registers 0.
- rst asserted mid-operation clears everything immediately (asynchronous). There is no valid pulse.
- Normal latency, start sampled at edge T:
  - busy=1 for cycles T+1..T+33 (32 iterations plus FIX).
  - valid=1 and result correct in cycle T+34.
- Special-case latency: valid=1 in cycle T+1, busy stays 0.
- result is registered; there is no combinational path from inputs to outputs.

## Configuration
- MULDIV_FAST_MUL_EN defined: MUL* ops use a single-cycle 33x33 signed multiply registered in the MUL state. Flow is IDLE -> MUL (1 cycle) -> DONE, with busy for 1 cycle and valid at T+2. FIX is skipped because sign handling is inherent in the 33-bit sign-extended operands.
- MULDIV_FAST_MUL_EN undefined: the iterative 34-cycle multiply described above.
- Division is identical in both builds.

## Structure
- Shared package muldiv_pkg holds:
  - muldiv_op_e enum (the funct3 encodings above).
  - muldiv_state_e enum.
  - MULDIV_ITER=32 and the special-case constants DIV0_QUOT=32'hFFFFFFFF and OVF_QUOT=32'h80000000.
- One sub-module, muldiv_iter, holds the shared iterative datapath: 64-bit accumulator/remainder register, counter, and add/subtract-shift step. The top level keeps the FSM, sign handling, special-case detection and output register.

## Test plan
- MUL 7 * 0xFFFFFFFD (-3), start at T -> busy T+1..T+33; valid only at T+34 with result 0xFFFFFFEB.
- High products:
  - MULH 0x80000000 * 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
- Special cases:
  - DIVU 5 / 0 -> 0xFFFFFFFF with valid at T+1 and busy never high.
  - REM 5 / 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- flush at T+10 with start also high -> IDLE at T+11, no valid, result unchanged. A start at T+5 during busy is ignored.
- Back-to-back: start again in the DONE cycle -> second valid 34 cycles later. rst pulsed at T+20 -> busy/valid/result 0 immediately and no valid afterwards.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
// Optional build macro: MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
package muldiv_pkg;

  localparam int XLEN        = 32;
  localparam int MULDIV_ITER = 32;
  localparam int CNT_W       = $clog2(MULDIV_ITER);

  localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] OVF_QUOT  = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } muldiv_state_e;

  function automatic logic is_div_op(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic src1_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic src2_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Shared iterative datapath: shift-add multiply and restoring divide over
// unsigned magnitudes, one bit per cycle, with a 64-bit accumulator.
module muldiv_iter
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [XLEN-1:0]   load_lo,
  input  logic [XLEN-1:0]   load_b,
  input  logic              mul_step,
  input  logic              div_step,
  output logic [2*XLEN-1:0] acc,
  output logic              last
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_part;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend bits becoming quotient}.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    acc_d = acc_q;
    b_d   = b_q;
    cnt_d = cnt_q;

    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_part = acc_q[2*XLEN-1:XLEN-1];
    div_ge   = div_part >= {1'b0, b_q};
    div_rem  = div_part[XLEN-1:0] - b_q;

    if (load) begin
      acc_d = {{XLEN{1'b0}}, load_lo};
      b_d   = load_b;
      cnt_d = '0;
    end else if (mul_step) begin
      acc_d = {mul_sum, acc_q[XLEN-1:1]};
      cnt_d = cnt_q + 1'b1;
    end else if (div_step) begin
      if (div_ge) acc_d = {div_rem, acc_q[XLEN-2:0], 1'b1};
      else        acc_d = {acc_q[2*XLEN-2:0], 1'b0};
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      acc_q <= acc_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc  = acc_q;
  assign last = (cnt_q == CNT_W'(MULDIV_ITER - 1));

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: FSM, sign handling, special cases, result register.
// Optional build macro: MULDIV_FAST_MUL_EN (single-cycle 33x33 signed multiply).
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      muldiv_op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  muldiv_state_e   state_q, state_d;
  muldiv_op_e      op_q, op_d;
  logic            neg_q, neg_d;
  logic            rem_neg_q, rem_neg_d;
  logic [XLEN-1:0] result_q, result_d;

  muldiv_op_e      op_in;
  logic            s1_neg, s2_neg;
  logic [XLEN-1:0] mag1, mag2;
  logic            in_div, div_zero, div_ovf, can_accept;
  logic [XLEN-1:0] special_res, fix_res;
  logic [2*XLEN-1:0] acc, prod;
  logic            iter_last, iter_load, mul_step, div_step;
  logic [XLEN-1:0] load_lo, load_b;

`ifdef MULDIV_FAST_MUL_EN
  logic [XLEN:0]     fa_q, fa_d, fb_q, fb_d;
  logic [2*XLEN-1:0] fast_prod;
`endif

  always_comb begin
    op_in    = muldiv_op_e'(muldiv_op);
    s1_neg   = src1_signed(op_in) & src1[XLEN-1];
    s2_neg   = src2_signed(op_in) & src2[XLEN-1];
    mag1     = s1_neg ? -src1 : src1;
    mag2     = s2_neg ? -src2 : src2;
    in_div   = is_div_op(op_in);
    div_zero = (src2 == '0);
    div_ovf  = (src1 == OVF_QUOT) && (src2 == '1) &&
               ((op_in == OP_DIV) || (op_in == OP_REM));
    can_accept = ((state_q == IDLE) || (state_q == DONE)) && start && !flush;
    // op[1] separates REM/REMU from DIV/DIVU
    if (div_zero) special_res = op_in[1] ? src1 : DIV0_QUOT;
    else          special_res = op_in[1] ? '0   : OVF_QUOT;
    load_lo  = in_div ? mag1 : mag2;
    load_b   = in_div ? mag2 : mag1;
  end

  always_comb begin
    prod = neg_q ? -acc : acc;
    case (op_q)
      OP_MUL:                       fix_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      default:                      fix_res = rem_neg_q ? -acc[2*XLEN-1:XLEN]
                                                        : acc[2*XLEN-1:XLEN];
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  assign fast_prod = $signed({{(XLEN-1){fa_q[XLEN]}}, fa_q}) *
                     $signed({{(XLEN-1){fb_q[XLEN]}}, fb_q});
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;
    iter_load = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
    fa_d      = fa_q;
    fb_d      = fb_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (can_accept) begin
          op_d      = op_in;
          neg_d     = s1_neg ^ s2_neg;
          rem_neg_d = s1_neg;
          if (in_div && (div_zero || div_ovf)) begin
            result_d = special_res;
            state_d  = DONE;
          end else if (in_div) begin
            iter_load = 1'b1;
            state_d   = DIV;
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            fa_d    = {src1_signed(op_in) & src1[XLEN-1], src1};
            fb_d    = {src2_signed(op_in) & src2[XLEN-1], src2};
`else
            iter_load = 1'b1;
`endif
            state_d = MUL;
          end
        end
      end
      MUL: begin
`ifdef MULDIV_FAST_MUL_EN
        result_d = (op_q == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
        state_d  = DONE;
`else
        if (iter_last) state_d = FIX;
`endif
      end
      DIV: begin
        if (iter_last) state_d = FIX;
      end
      FIX: begin
        result_d = fix_res;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase

    // Flush beats everything, including a same-cycle start.
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  assign mul_step = 1'b0;
`else
  assign mul_step = (state_q == MUL);
`endif
  assign div_step = (state_q == DIV);

  muldiv_iter u_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (iter_load),
    .load_lo  (load_lo),
    .load_b   (load_b),
    .mul_step (mul_step),
    .div_step (div_step),
    .acc      (acc),
    .last     (iter_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= OP_MUL;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
`ifdef MULDIV_FAST_MUL_EN
      fa_q      <= '0;
      fb_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
`ifdef MULDIV_FAST_MUL_EN
      fa_q      <= fa_d;
      fb_q      <= fb_d;
`endif
    end
  end

  assign busy   = (state_q == MUL) || (state_q == DIV) || (state_q == FIX);
  assign valid  = (state_q == DONE);
  assign result = result_q;

endmodule
